pa_spsram_1024x4_ctrl: RTL
==========================

PA_SPSRAM_1024X4_CTRL -- requirements
Module: pa_spsram_1024x4_ctrl
Initiator side of the 1024x4 single-port SRAM interface: clears the array after reset, then serves single-request read/write traffic and returns read data.

Interface
REQ-001 SHALL have port forever_cpuclk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port cpurst_b  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port init_req  in  1  pulse requesting a full array re-clear.
REQ-004 SHALL have port req_vld  in  1  request valid.
REQ-005 SHALL have port req_rdy  out  1  request accepted when req_vld & req_rdy.
REQ-006 SHALL have port req_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  in  10  word address.
REQ-008 SHALL have port req_wdata  in  4  write data.
REQ-009 SHALL have port req_wmask  in  4  per-bit write enable, 1 = write.
REQ-010 SHALL have port rsp_vld  out  1  read data valid.
REQ-011 SHALL have port rsp_rdy  in  1  read data consumed when rsp_vld & rsp_rdy.
REQ-012 SHALL have port rsp_rdata  out  4  read data.
REQ-013 SHALL have port init_done  out  1  array clear complete, module serving requests.
REQ-014 SHALL have port sram_a  out  10  SRAM address.
REQ-015 SHALL have port sram_cen  out  1  SRAM chip enable, active-low.
REQ-016 SHALL have port sram_gwen  out  1  SRAM global write enable, active-low.
REQ-017 SHALL have port sram_wen  out  4  SRAM bit write enables, active-low.
REQ-018 SHALL have port sram_d  out  4  SRAM write data.
REQ-019 SHALL have port sram_q  in  4  SRAM read data, valid one cycle after a read access.

Function
REQ-020 SHALL implement states INIT and IDLE, plus a 1-bit rd_pend flag and a 10-bit clear counter init_cnt.
REQ-021 SHALL, in INIT, drive sram_cen=0, sram_gwen=0, sram_wen=4'h0, sram_d=4'h0, sram_a=init_cnt, and increment init_cnt each cycle.
REQ-022 SHALL move INIT->IDLE on the edge where init_cnt==1023: exactly 1024 clearing writes, then init_done=1 from the next cycle and init_cnt wraps to 0.
REQ-023 SHALL drive req_rdy = init_done & ~rd_pend & ~rsp_vld & ~init_req, combinationally.
REQ-024 SHALL, on an accepted write, drive in the same cycle sram_cen=0, sram_gwen=0, sram_wen=~req_wmask, sram_a=req_addr, sram_d=req_wdata.
REQ-025 SHALL issue an accepted write with req_wmask=4'h0 unchanged (sram_wen=4'hF), leaving memory unmodified.
REQ-026 SHALL, on an accepted read, drive in the same cycle sram_cen=0, sram_gwen=1, sram_wen=4'hF, sram_a=req_addr, sram_d=4'h0, and set rd_pend.
REQ-027 SHALL, in the cycle with rd_pend=1, capture sram_q into rsp_rdata at the closing edge, clear rd_pend and set rsp_vld.
REQ-028 SHALL therefore assert rsp_vld two cycles after read acceptance, and hold rsp_vld and rsp_rdata stable until rsp_rdy=1.
REQ-029 SHALL clear rsp_vld on the edge where rsp_vld & rsp_rdy; rsp_rdata keeps its last value.
REQ-030 SHALL limit reads to one outstanding, giving maximum read throughput of one per 3 cycles with rsp_rdy tied high. Writes sustain one per cycle.
REQ-031 SHALL, in IDLE with no access, drive sram_cen=1, sram_gwen=1, sram_wen=4'hF, sram_a=0, sram_d=0.
REQ-032 SHALL act on init_req only when init_done & ~rd_pend & ~rsp_vld; on that edge it SHALL enter INIT, clear init_done and set init_cnt=0.
REQ-033 SHALL ignore init_req at all other times, with no latching.
REQ-034 SHALL give init_req priority over a same-cycle req_vld; the request is not accepted (req_rdy=0).
REQ-035 SHALL not accept requests in INIT; a req_vld held through INIT is accepted in the first IDLE cycle.

Reset
REQ-036 SHALL, while cpurst_b=0, force state=INIT, init_cnt=0, rd_pend=0, rsp_vld=0, rsp_rdata=4'h0, init_done=0, req_rdy=0.
REQ-037 SHALL permit SRAM outputs to show the INIT write to address 0 with data 0 during reset; this is harmless.
REQ-038 SHALL restart the clear from address 0 on reset assertion mid-INIT or mid-read; any pending read and response are discarded.

Verification
REQ-039 SHALL cover: release reset, hold req_vld=0 -> 1024 consecutive writes, sram_a 0..1023, wen=0, d=0; init_done rises in cycle 1024; reads of 0x000, 0x3FF return 4'h0.
REQ-040 SHALL cover: write addr 0x155 data 4'hA mask 4'hF, then read 0x155 with rsp_rdy=1 -> sram_wen=4'h0 on write; rsp_vld 2 cycles after read acceptance, rsp_rdata=4'hA.
REQ-041 SHALL cover: after REQ-040, write 0x155 data 4'h5 mask 4'h3, read back -> sram_wen=4'hC; rsp_rdata=4'h9.
REQ-042 SHALL cover: read with rsp_rdy=0 for 5 cycles -> rsp_vld and rsp_rdata stable, req_rdy=0 throughout; req_rdy returns 1 the cycle after the rsp_rdy handshake.
REQ-043 SHALL cover: init_req asserted with rsp_vld=1 -> ignored. Then init_req asserted together with req_vld in IDLE -> request not accepted, INIT re-entered, init_done=0 for 1024 cycles.
REQ-044 SHALL cover: cpurst_b pulsed low at init_cnt=500 -> sequence restarts at sram_a=0, init_done first rises 1024 cycles after release.

Source files
------------

// File: rtl/pa_spsram_1024x4_ctrl.sv
// Initiator for a 1024x4 single-port SRAM. After reset (or an init request) it
// clears every word, then serves one request at a time: writes go straight to
// the array, reads return sram_q two cycles after acceptance.
module pa_spsram_1024x4_ctrl (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       init_req,
  input  logic       req_vld,
  output logic       req_rdy,
  input  logic       req_wr,
  input  logic [9:0] req_addr,
  input  logic [3:0] req_wdata,
  input  logic [3:0] req_wmask,
  output logic       rsp_vld,
  input  logic       rsp_rdy,
  output logic [3:0] rsp_rdata,
  output logic       init_done,
  output logic [9:0] sram_a,
  output logic       sram_cen,
  output logic       sram_gwen,
  output logic [3:0] sram_wen,
  output logic [3:0] sram_d,
  input  logic [3:0] sram_q
);

  localparam logic [9:0] LastAddr = 10'h3FF;

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e     state_q, state_d;
  logic [9:0] init_cnt_q, init_cnt_d;
  logic       init_done_q, init_done_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic [3:0] rsp_rdata_q, rsp_rdata_d;

  logic req_acc;
  logic init_go;

  // init_done_q is only ever set in StIdle, so it also gates request acceptance.
  assign req_rdy   = init_done_q & ~rd_pend_q & ~rsp_vld_q & ~init_req;
  assign req_acc   = req_vld & req_rdy;
  // A re-clear is only honoured when no read is in flight; otherwise it is dropped.
  assign init_go   = init_req & init_done_q & ~rd_pend_q & ~rsp_vld_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

  // Next-state: clear sequencing, read tracking and response hold.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rd_pend_d   = rd_pend_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StInit: begin
        // Counter wraps to 0 on the final clearing write.
        init_cnt_d = init_cnt_q + 10'd1;
        if (init_cnt_q == LastAddr) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (init_go) begin
          state_d     = StInit;
          init_done_d = 1'b0;
          init_cnt_d  = '0;
        end
      end
      default: state_d = StInit;
    endcase

    if (req_acc && !req_wr) begin
      rd_pend_d = 1'b1;
    end

    // rd_pend and rsp_vld are never both set, so these branches are exclusive.
    if (rd_pend_q) begin
      rsp_rdata_d = sram_q;
      rd_pend_d   = 1'b0;
      rsp_vld_d   = 1'b1;
    end else if (rsp_vld_q && rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end
  end

  // SRAM pins: clearing write in StInit, pass-through of accepted requests otherwise.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = 4'hF;
    sram_a    = '0;
    sram_d    = '0;
    if (state_q == StInit) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = 4'h0;
      sram_a    = init_cnt_q;
    end else if (req_acc) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_wmask;
        sram_d    = req_wdata;
      end
    end
  end

  // State registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
